// File: rtl/data_cache_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped data cache.
// Latency: n/a (types, constants and a byte-select helper only).
// Backpressure: n/a.
package data_cache_pkg;

  localparam int ADDR_W      = 8;
  localparam int NUM_BLOCKS  = 8;
  localparam int BLOCK_BYTES = 4;
  localparam int IDX_W       = 3;
  localparam int OFF_W       = 2;
  localparam int TAG_W       = ADDR_W - IDX_W - OFF_W;
  localparam int BLOCK_W     = 8 * BLOCK_BYTES;
  localparam int MADDR_W     = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_t;

  // Byte 0 of a block lives in bits [7:0].
  function automatic logic [7:0] byte_sel(input logic [BLOCK_W-1:0] blk,
                                          input logic [OFF_W-1:0]   off);
    return blk[off*8 +: 8];
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Line storage for the cache: data, tag, valid and dirty per line, read at idx.
// Latency: combinational read of the indexed line; byte write / block fill commit on the next posedge.
// Backpressure: none; the caller decides when byte_we/fill_we fire (fill wins if both are high).
// Ports: clk, rst_n (async active-low, clears everything); idx selects the line for read and write;
//        byte_we/byte_off/byte_dat store one byte and set dirty; fill_we/fill_tag/fill_dat load a
//        whole block clean and valid; line_* return the indexed line.
module cache_line_store
  import data_cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   idx,
  input  logic               byte_we,
  input  logic [OFF_W-1:0]   byte_off,
  input  logic [7:0]         byte_dat,
  input  logic               fill_we,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [BLOCK_W-1:0] fill_dat,
  output logic [BLOCK_W-1:0] line_dat,
  output logic [TAG_W-1:0]   line_tag,
  output logic               line_vld,
  output logic               line_dirty
);

  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      data_q[idx]  <= fill_dat;
      tag_q[idx]   <= fill_tag;
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (byte_we) begin
      data_q[idx][byte_off*8 +: 8] <= byte_dat;
      dirty_q[idx]                 <= 1'b1;
    end
  end

  assign line_dat   = data_q[idx];
  assign line_tag   = tag_q[idx];
  assign line_vld   = valid_q[idx];
  assign line_dirty = dirty_q[idx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back write-allocate byte cache between the cpu port and block memory.
// Latency: hits 0 stall (write commits next posedge); clean miss Tmem+1, dirty miss 2*Tmem+1 cycles.
// Backpressure: BUSYWAIT stalls the cpu, which holds its request; mem_busywait holds the FSM in WRITEBACK/FETCH.
// Ports: CLK, RESET (async active-low); cpu side READ/WRITE/ADDRESS/WRITEDATA in, READDATA/BUSYWAIT out;
//        memory side mem_read/mem_write/mem_address/mem_writedata out (registered, Moore),
//        mem_readdata/mem_busywait in.
module data_cache
  import data_cache_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               READ,
  input  logic               WRITE,
  input  logic [ADDR_W-1:0]  ADDRESS,
  input  logic [7:0]         WRITEDATA,
  output logic [7:0]         READDATA,
  output logic               BUSYWAIT,
  output logic               mem_read,
  output logic               mem_write,
  output logic [MADDR_W-1:0] mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait
);

  state_t             state;
  logic [TAG_W-1:0]   tag_in;
  logic [IDX_W-1:0]   idx;
  logic [OFF_W-1:0]   off;
  logic [BLOCK_W-1:0] line_dat;
  logic [TAG_W-1:0]   line_tag;
  logic               line_vld;
  logic               line_dirty;
  logic               request;
  logic               hit;
  logic               byte_we;
  logic               fill_we;

  assign tag_in  = ADDRESS[ADDR_W-1 -: TAG_W];
  assign idx     = ADDRESS[OFF_W +: IDX_W];
  assign off     = ADDRESS[OFF_W-1:0];
  assign request = READ | WRITE;
  assign hit     = line_vld && (line_tag == tag_in);

  // Gated by RESET so the cpu sees the stall drop the moment reset is applied mid-miss.
  assign BUSYWAIT = RESET && request && !((state == IDLE) && hit);
  assign READDATA = byte_sel(line_dat, off);

  // READ and WRITE together behave as a write.
  assign byte_we = (state == IDLE) && WRITE && hit;
  assign fill_we = (state == FETCH) && !mem_busywait;

  cache_line_store u_store (
    .clk        (CLK),
    .rst_n      (RESET),
    .idx        (idx),
    .byte_we    (byte_we),
    .byte_off   (off),
    .byte_dat   (WRITEDATA),
    .fill_we    (fill_we),
    .fill_tag   (tag_in),
    .fill_dat   (mem_readdata),
    .line_dat   (line_dat),
    .line_tag   (line_tag),
    .line_vld   (line_vld),
    .line_dirty (line_dirty)
  );

  // Memory-side outputs are loaded on state entry; ADDRESS is held by the cpu
  // for the whole miss, so the fetch address stays consistent.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request && !hit) begin
            if (line_vld && line_dirty) begin
              state         <= WRITEBACK;
              mem_write     <= 1'b1;
              mem_address   <= {line_tag, idx};
              mem_writedata <= line_dat;
            end else begin
              state       <= FETCH;
              mem_read    <= 1'b1;
              mem_address <= {tag_in, idx};
            end
          end
        end
        WRITEBACK: begin
          if (!mem_busywait) begin
            state         <= FETCH;
            mem_write     <= 1'b0;
            mem_read      <= 1'b1;
            mem_address   <= {tag_in, idx};
            mem_writedata <= '0;
          end
        end
        FETCH: begin
          if (!mem_busywait) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_address <= '0;
          end
        end
        default: begin
          state         <= IDLE;
          mem_read      <= 1'b0;
          mem_write     <= 1'b0;
          mem_address   <= '0;
          mem_writedata <= '0;
        end
      endcase
    end
  end

endmodule
